// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - PARITY_* : parity mode constants (parameter values for PARITY)
//   - uart_state_t : frame state encoding
//   - parity_bit() : parity of the low nbits of a payload
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity is the XOR of the payload bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [8:0] data, input int nbits, input int mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: clearable divide-by-CLK_DIV counter.
//   sys_clk  : system clock
//   sys_rst  : asynchronous active-high reset
//   clear    : hold the counter at 0 (no bit_end while asserted)
//   bit_end  : one-cycle pulse in the last cycle of each bit period
module uart_baud_gen #(
    parameter int CLK_DIV = 434
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)                cnt <= '0;
        else if (clear || bit_end)  cnt <= '0;
        else                        cnt <= cnt + CNT_W'(1);
    end

    assign bit_end = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//   sys_clk  : system clock, rising edge
//   sys_rst  : asynchronous active-high reset
//   tx_data  : payload, sampled on tx_valid && tx_ready
//   tx_valid : producer has data
//   tx_ready : block can accept (IDLE only)
//   tx       : registered serial line, idle high
//   tx_busy  : frame in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    uart_state_t          state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
    logic                 par;
    logic                 tx_d;
    logic                 bit_end;
    logic                 accept;

    assign accept = tx_valid && (state == ST_IDLE);

    // Baud counter is held at zero in IDLE so the start bit is a full period.
    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (accept)  state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && bit_cnt == LAST_DATA)
                           state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && bit_cnt == LAST_STOP) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the bit counter restarts on every state change
    // so it indexes data bits and then stop bits.
    always_comb begin
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        if (accept) begin
            shreg_d   = tx_data;
            bit_cnt_d = '0;
        end else if (bit_end) begin
            bit_cnt_d = (state != state_d) ? '0 : bit_cnt + BIT_W'(1);
            if (state == ST_DATA) shreg_d = shreg >> 1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            if (accept) par <= parity_bit(9'(tx_data), DATA_BITS, PARITY);
        end
    end

    // Output logic: tx is computed from the upcoming state so the flop
    // changes on the same edge as the state, keeping the line glitch-free.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = par;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) tx <= 1'b1;
        else         tx <= tx_d;
    end

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. Four instances share one clock:
//   0: CLK_DIV=4, no parity, 1 stop    1: even parity
//   2: odd parity                      3: 2 stop bits
// Expected frames are hand-built bit vectors, bit i = serial slot i.
module tb_uart_tx;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic [3:0] rst;
    logic [3:0] v;
    logic [7:0] d [4];
    logic [3:0] txw, rdy, bsy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sys_clk(clk), .sys_rst(rst[0]), .tx_data(d[0]), .tx_valid(v[0]),
        .tx_ready(rdy[0]), .tx(txw[0]), .tx_busy(bsy[0]));
    uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .sys_clk(clk), .sys_rst(rst[1]), .tx_data(d[1]), .tx_valid(v[1]),
        .tx_ready(rdy[1]), .tx(txw[1]), .tx_busy(bsy[1]));
    uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .sys_clk(clk), .sys_rst(rst[2]), .tx_data(d[2]), .tx_valid(v[2]),
        .tx_ready(rdy[2]), .tx(txw[2]), .tx_busy(bsy[2]));
    uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .sys_clk(clk), .sys_rst(rst[3]), .tx_data(d[3]), .tx_valid(v[3]),
        .tx_ready(rdy[3]), .tx(txw[3]), .tx_busy(bsy[3]));

    typedef struct {
        int          k;
        logic [7:0]  data;
        int          nb;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int j, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, j, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called positioned at cycle 1 (first cycle after accept). Checks every
    // cycle of the frame, then the IDLE cycle that follows it.
    task automatic run_frame(input int k, input logic [11:0] exp, input int nb,
                             input string name, input int pulse_at);
        for (int j = 1; j <= nb * CD; j++) begin
            if (j > 1) step();
            if (pulse_at != 0 && j == pulse_at) begin
                d[k] = 8'hFF;
                v[k] = 1'b1;
            end
            if (pulse_at != 0 && j == pulse_at + 1) v[k] = 1'b0;
            chk({name, ".tx"}, j, txw[k], exp[(j - 1) / CD]);
            chk({name, ".ready"}, j, rdy[k], 1'b0);
            chk({name, ".busy"}, j, bsy[k], 1'b1);
        end
        step();
        chk({name, ".end_tx"}, nb * CD + 1, txw[k], 1'b1);
        chk({name, ".end_ready"}, nb * CD + 1, rdy[k], 1'b1);
        chk({name, ".end_busy"}, nb * CD + 1, bsy[k], 1'b0);
    endtask

    task automatic start(input int k, input logic [7:0] data);
        d[k] = data;
        v[k] = 1'b1;
        step();
        v[k] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 8'h55, 10, 12'h2AA, "np_55"};
        vecs[1] = '{0, 8'h00, 10, 12'h200, "np_00"};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE, "np_FF"};
        vecs[3] = '{0, 8'hA3, 10, 12'h346, "np_A3"};
        vecs[4] = '{1, 8'hA3, 11, 12'h546, "even_A3"};
        vecs[5] = '{2, 8'hA3, 11, 12'h746, "odd_A3"};
        vecs[6] = '{1, 8'h01, 11, 12'h602, "even_01"};
        vecs[7] = '{2, 8'h01, 11, 12'h402, "odd_01"};
        vecs[8] = '{2, 8'h00, 11, 12'h600, "odd_00"};
        vecs[9] = '{3, 8'h55, 11, 12'h6AA, "stop2_55"};

        rst = 4'hF;
        v   = 4'h0;
        for (int k = 0; k < 4; k++) d[k] = 8'h00;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset.tx", 0, txw[k], 1'b1);
            chk("reset.ready", 0, rdy[k], 1'b1);
            chk("reset.busy", 0, bsy[k], 1'b0);
        end
        step();
        step();
        rst = 4'h0;
        step();

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            start(vecs[i].k, vecs[i].data);
            run_frame(vecs[i].k, vecs[i].exp, vecs[i].nb, vecs[i].name, 0);
            step();
        end

        // Back-to-back: tx_valid held high, data changed after first accept
        d[0] = 8'h01;
        v[0] = 1'b1;
        step();
        d[0] = 8'h80;
        run_frame(0, 12'h202, 10, "b2b_first", 0);
        step();
        v[0] = 1'b0;
        run_frame(0, 12'h300, 10, "b2b_second", 0);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("b2b_nodup.tx", j, txw[0], 1'b1);
            chk("b2b_nodup.ready", j, rdy[0], 1'b1);
        end

        // 0xFF pulsed during DATA of a 0x00 frame must be ignored
        start(0, 8'h00);
        run_frame(0, 12'h200, 10, "ignore_pulse", 10);
        for (int j = 0; j < 6; j++) begin
            step();
            chk("ignore_after.tx", j, txw[0], 1'b1);
            chk("ignore_after.busy", j, bsy[0], 1'b0);
        end

        // Reset during data bit 3 (cycles 17..20) of a 0x00 frame
        start(0, 8'h00);
        for (int j = 2; j <= 18; j++) step();
        chk("rst_mid.tx_before", 18, txw[0], 1'b0);
        rst[0] = 1'b1;
        #1;
        chk("rst_mid.tx", 18, txw[0], 1'b1);
        chk("rst_mid.ready", 18, rdy[0], 1'b1);
        chk("rst_mid.busy", 18, bsy[0], 1'b0);
        step();
        rst[0] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rst_after.tx", j, txw[0], 1'b1);
            chk("rst_after.ready", j, rdy[0], 1'b1);
        end
        start(0, 8'h3C);
        run_frame(0, 12'h278, 10, "rst_then_3C", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
